// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Opcodes, flag bit positions and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PASA = 4'd1;
    localparam logic [3:0] OP_PASB = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_INC  = 4'd8;
    localparam logic [3:0] OP_DEC  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_SETC = 4'd12;
    localparam logic [3:0] OP_CLRC = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_RSV  = 4'd15;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per clock.
// Ports: i_start/i_abort control, i_a/i_b operands, o_done/o_result.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_busy;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_busy    = (r_cnt != '0);
    assign w_step    = r_mplier[0] ? r_mcand : '0;
    assign w_acc_nxt = r_acc + w_step;

    // Final step: the result is the accumulator after this edge's add,
    // so it is exposed combinationally for the top to register.
    assign o_done   = (r_cnt == CNT_W'(1)) & ~i_abort;
    assign o_result = w_acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_abort) begin
            r_cnt    <= '0;
        end else if (i_start && !w_busy) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (w_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/exec_alu_seq.sv
// Registered execute-stage ALU with flag register and iterative MUL.
// Ports: valid/ready input, op/in1/in2, flush, flag_ld/flag_in, out/out_valid/flag.
module exec_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    input  logic             flag_ld,
    input  logic [2:0]       flag_in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [2:0]       flag
);

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic [2:0]       r_flag;

    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_abort;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_res;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_res;
    logic             w_res_v;
    logic             w_upd_zn;
    logic             w_upd_c;
    logic             w_c;

    assign in_ready    = (r_state == S_IDLE);
    assign w_accept    = in_valid & in_ready & ~flush;
    assign w_mul_start = w_accept & (op == OP_MUL);
    assign w_mul_abort = flush & (r_state == S_MUL_BUSY);

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign flag      = r_flag;

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_mul_start),
        .i_abort  (w_mul_abort),
        .i_a      (in1),
        .i_b      (in2),
        .o_done   (w_mul_done),
        .o_result (w_mul_res)
    );

    // Top bit of the extended difference is the unsigned borrow.
    assign w_sum  = {1'b0, in1} + {1'b0, in2};
    assign w_diff = {1'b0, in1} - {1'b0, in2};
    assign w_inc  = {1'b0, in1} + (WIDTH+1)'(1);

    always_comb begin
        w_res    = '0;
        w_res_v  = 1'b0;
        w_upd_zn = 1'b0;
        w_upd_c  = 1'b0;
        w_c      = 1'b0;
        unique case (op)
            OP_PASA: begin w_res = in1; w_res_v = 1'b1; end
            OP_PASB: begin w_res = in2; w_res_v = 1'b1; end
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH];
                w_res_v = 1'b1; w_upd_zn = 1'b1; w_upd_c = 1'b1;
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH];
                w_res_v = 1'b1; w_upd_zn = 1'b1; w_upd_c = 1'b1;
            end
            OP_AND: begin
                w_res = in1 & in2; w_res_v = 1'b1; w_upd_zn = 1'b1;
            end
            OP_OR: begin
                w_res = in1 | in2; w_res_v = 1'b1; w_upd_zn = 1'b1;
            end
            OP_NOT: begin
                w_res = ~in2; w_res_v = 1'b1; w_upd_zn = 1'b1;
            end
            OP_INC: begin
                w_res = w_inc[WIDTH-1:0]; w_c = w_inc[WIDTH];
                w_res_v = 1'b1; w_upd_zn = 1'b1; w_upd_c = 1'b1;
            end
            OP_DEC: begin
                w_res = in1 - WIDTH'(1); w_c = (in1 == '0);
                w_res_v = 1'b1; w_upd_zn = 1'b1; w_upd_c = 1'b1;
            end
            OP_SHL: begin
                w_res = {in1[WIDTH-2:0], 1'b0}; w_c = in1[WIDTH-1];
                w_res_v = 1'b1; w_upd_zn = 1'b1; w_upd_c = 1'b1;
            end
            OP_SHR: begin
                w_res = {1'b0, in1[WIDTH-1:1]}; w_c = in1[0];
                w_res_v = 1'b1; w_upd_zn = 1'b1; w_upd_c = 1'b1;
            end
            OP_SETC: begin w_c = 1'b1; w_upd_c = 1'b1; end
            OP_CLRC: begin w_c = 1'b0; w_upd_c = 1'b1; end
            default: begin end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_flag      <= 3'b000;
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (op == OP_MUL) r_state <= S_MUL_BUSY;
                        if (w_res_v) begin
                            r_out       <= w_res;
                            r_out_valid <= 1'b1;
                        end
                        if (w_upd_zn) begin
                            r_flag[FLG_Z] <= (w_res == '0);
                            r_flag[FLG_N] <= w_res[WIDTH-1];
                        end
                        if (w_upd_c) r_flag[FLG_C] <= w_c;
                    end
                end
                S_MUL_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (w_mul_done) begin
                        r_state       <= S_IDLE;
                        r_out         <= w_mul_res;
                        r_out_valid   <= 1'b1;
                        r_flag[FLG_Z] <= (w_mul_res == '0);
                        r_flag[FLG_N] <= w_mul_res[WIDTH-1];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A restore wins over any flag update on the same edge.
            if (flag_ld) r_flag <= flag_in;
        end
    end

endmodule

// File: tb/tb_exec_alu_seq.sv
// Self-checking bench for exec_alu_seq (WIDTH=16 and WIDTH=8 instances).
// Reference model computes results with plain modular arithmetic.
module tb_exec_alu_seq;

    localparam int W = 16;
    localparam longint M = 64'd1 << W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         flush;
    logic         flag_ld;
    logic [2:0]   flag_in;
    logic [W-1:0] out;
    logic         out_valid;
    logic [2:0]   flag;

    logic         b_in_valid;
    logic         b_in_ready;
    logic [3:0]   b_op;
    logic [7:0]   b_in1;
    logic [7:0]   b_in2;
    logic         b_flush;
    logic         b_flag_ld;
    logic [2:0]   b_flag_in;
    logic [7:0]   b_out;
    logic         b_out_valid;
    logic [2:0]   b_flag;

    int n_vec = 0;
    int n_err = 0;

    longint     m_out  = 0;
    logic [2:0] m_flag = 3'b000;

    exec_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .flag_ld   (flag_ld),
        .flag_in   (flag_in),
        .out       (out),
        .out_valid (out_valid),
        .flag      (flag)
    );

    exec_alu_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .op        (b_op),
        .in1       (b_in1),
        .in2       (b_in2),
        .flush     (b_flush),
        .flag_ld   (b_flag_ld),
        .flag_in   (b_flag_in),
        .out       (b_out),
        .out_valid (b_out_valid),
        .flag      (b_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: updates m_out/m_flag ({N,C,Z}).
    task automatic ref_step(input int o, input longint a, input longint b,
                            output bit v);
        longint r;
        bit c;
        bit zn;
        bit uc;
        r = 0; c = 0; zn = 0; uc = 0; v = 1;
        case (o)
            1:  r = a;
            2:  r = b;
            3:  begin r = (a + b) % M; c = (a + b) >= M; zn = 1; uc = 1; end
            4:  begin r = (a - b + M) % M; c = a < b; zn = 1; uc = 1; end
            5:  begin r = a & b; zn = 1; end
            6:  begin r = a | b; zn = 1; end
            7:  begin r = M - 1 - b; zn = 1; end
            8:  begin r = (a + 1) % M; c = (a == M - 1); zn = 1; uc = 1; end
            9:  begin r = (a + M - 1) % M; c = (a == 0); zn = 1; uc = 1; end
            10: begin r = (2 * a) % M; c = a >= M / 2; zn = 1; uc = 1; end
            11: begin r = a / 2; c = a % 2; zn = 1; uc = 1; end
            12: begin v = 0; m_flag[1] = 1'b1; end
            13: begin v = 0; m_flag[1] = 1'b0; end
            14: begin r = (a * b) % M; zn = 1; end
            default: v = 0;
        endcase
        if (v) m_out = r;
        if (zn) begin
            m_flag[0] = (r == 0);
            m_flag[2] = (r >= M / 2);
        end
        if (uc) m_flag[1] = c;
    endtask

    task automatic run_op(input int o, input longint a, input longint b,
                          input bit ld, input logic [2:0] fin,
                          input bit inj);
        bit v;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o[3:0];
        in1      = a[W-1:0];
        in2      = b[W-1:0];
        flag_ld  = ld;
        flag_in  = fin;
        chk("ready_before", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flag_ld  = 1'b0;
        if (o == 14) begin
            if (ld) m_flag = fin;
            chk("mul_accept_ready", in_ready, 0);
            chk("mul_accept_ovalid", out_valid, 0);
            if (inj) begin
                in_valid = 1'b1;
                op       = 4'd12;
            end
            repeat (W - 1) begin
                @(posedge clk);
                #1;
                chk("mul_busy_ready", in_ready, 0);
                chk("mul_busy_ovalid", out_valid, 0);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            ref_step(o, a, b, v);
            chk("mul_ovalid", out_valid, 1);
            chk("mul_out", out, m_out);
            chk("mul_flag", flag, m_flag);
            chk("mul_done_ready", in_ready, 1);
        end else begin
            ref_step(o, a, b, v);
            if (ld) m_flag = fin;
            chk("op_ovalid", out_valid, v);
            chk("op_out", out, m_out);
            chk("op_flag", flag, m_flag);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; op = '0; in1 = '0; in2 = '0;
        flush = 1'b0; flag_ld = 1'b0; flag_in = '0;
        b_in_valid = 1'b0; b_op = '0; b_in1 = '0; b_in2 = '0;
        b_flush = 1'b0; b_flag_ld = 1'b0; b_flag_in = '0;

        #12;
        chk("rst_out", out, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_flag", flag, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        run_op(3, 'hFFFF, 'h0001, 0, 3'b000, 0);
        chk("add_wrap_flag", flag, 3'b011);
        @(posedge clk);
        #1;
        chk("ovalid_pulse", out_valid, 0);

        run_op(4, 'h0003, 'h0005, 0, 3'b000, 0);
        chk("sub_out", out, 'hFFFE);
        run_op(11, 'h0001, 'h0000, 0, 3'b000, 0);
        chk("shr_flag", flag, 3'b011);

        run_op(13, 0, 0, 0, 3'b000, 0);
        run_op(14, 'h0123, 'h0010, 0, 3'b000, 1);
        chk("mul_1230", out, 'h1230);
        chk("setc_blocked", flag, 3'b000);

        run_op(12, 0, 0, 0, 3'b000, 0);
        @(negedge clk);
        in_valid = 1'b1; op = 4'd14; in1 = '0; in2 = 'hFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ovalid", out_valid, 0);
        chk("flush_out", out, m_out);
        chk("flush_flag", flag, m_flag);
        chk("flush_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("flush_after_ovalid", out_valid, 0);

        run_op(3, 1, 1, 1, 3'b101, 0);
        chk("fld_flag", flag, 3'b101);
        chk("fld_out", out, 2);

        @(negedge clk);
        in_valid = 1'b1; op = 4'd14; in1 = 'd5; in2 = 'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out", out, 0);
        chk("arst_ovalid", out_valid, 0);
        chk("arst_flag", flag, 0);
        chk("arst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        m_out = 0;
        m_flag = 3'b000;
        repeat (W) @(posedge clk);
        #1;
        chk("arst_discard_ovalid", out_valid, 0);
        chk("arst_discard_out", out, 0);

        for (int i = 0; i < 250; i++) begin
            int o;
            bit ld;
            o  = int'($urandom_range(0, 15));
            ld = ($urandom_range(0, 7) == 0);
            if (o == 14 && $urandom_range(0, 2) != 0) o = 3;
            run_op(o, longint'($urandom_range(0, 32'hFFFF)),
                   longint'($urandom_range(0, 32'hFFFF)),
                   ld, 3'($urandom_range(0, 7)), 0);
        end
        run_op(9, 0, 0, 0, 3'b000, 0);
        run_op(10, 'h8000, 0, 0, 3'b000, 0);
        run_op(8, 'hFFFF, 0, 0, 3'b000, 0);

        @(negedge clk);
        b_in_valid = 1'b1; b_op = 4'd14; b_in1 = 8'h0F; b_in2 = 8'h11;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("w8_accept_ready", b_in_ready, 0);
        repeat (7) begin
            @(posedge clk);
            #1;
            chk("w8_busy_ovalid", b_out_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("w8_ovalid", b_out_valid, 1);
        chk("w8_out", b_out, 8'hFF);
        chk("w8_flag", b_flag, 3'b100);
        chk("w8_ready", b_in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
